// File: rtl/de_serial_pkg.sv
// -----------------------------------------------------------------------------
// de_serial_pkg
// Shared types and constants for the de_serial receive path.
//   aligner_state_t : word_aligner frame-alignment states
//   SYNC_DEFAULT    : default W-bit frame sync pattern (W = 25)
//   cnt_width()     : counter width for a modulus, never less than 1 bit
// -----------------------------------------------------------------------------
package de_serial_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } aligner_state_t;

    localparam logic [24:0] SYNC_DEFAULT = 25'h1F35A4C;

    // Width able to hold 0..n-1; a modulus of 1 still needs one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/word_aligner_match.sv
// -----------------------------------------------------------------------------
// word_aligner_match
// Combinational sync search across all W bit offsets of a 2W-bit window.
//   win  in  2W  {prev, in_data}; MSB is the earliest bit
//   sync in  W   pattern to search for
//   hit  out 1   pattern found at some offset
//   k    out KW  lowest matching offset (0 = prev itself), 0 when no hit
// -----------------------------------------------------------------------------
module word_aligner_match #(
    parameter int W  = 25,
    parameter int KW = 5
) (
    input  logic [2*W-1:0] win,
    input  logic [W-1:0]   sync,
    output logic           hit,
    output logic [KW-1:0]  k
);

    logic [W-1:0] hit_vec;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cand
            assign hit_vec[gi] = (win[2*W-1-gi -: W] == sync);
        end
    endgenerate

    // Scan from the top down so the last assignment wins: lowest k.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit = 1'b1;
                k   = KW'(i);
            end
        end
    end

endmodule

// File: rtl/word_aligner.sv
// -----------------------------------------------------------------------------
// word_aligner
// Finds a W-bit sync pattern at any bit phase of a packed word stream,
// qualifies it over LOCK_N frames and emits bit-aligned words with a
// start-of-frame flag while locked. No backpressure.
//   clk       in  1   clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   in_valid  in  1   in_data carries a new word
//   in_data   in  W   raw word, MSB earliest
//   out_valid out 1   out_data is an aligned word (only while locked)
//   out_data  out W   aligned word, MSB first
//   out_sof   out 1   out_data is the frame's sync word
//   locked    out 1   alignment established
//   offset    out $clog2(W)  bit offset in use
// -----------------------------------------------------------------------------
module word_aligner
    import de_serial_pkg::*;
#(
    parameter int           W      = 25,
    parameter logic [W-1:0] SYNC   = SYNC_DEFAULT,
    parameter int           FRAME  = 8,
    parameter int           LOCK_N = 3,
    parameter int           LOSS_N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_sof,
    output logic                 locked,
    output logic [$clog2(W)-1:0] offset
);

    localparam int OW  = $clog2(W);
    localparam int FCW = cnt_width(FRAME);
    localparam int HCW = cnt_width(LOCK_N + 1);
    localparam int MCW = cnt_width(LOSS_N + 1);

    aligner_state_t state_reg, state_next;
    logic [W-1:0]   prev_reg, prev_next;
    logic [FCW-1:0] fcnt_reg, fcnt_next;
    logic [HCW-1:0] hits_reg, hits_next;
    logic [MCW-1:0] miss_reg, miss_next;
    logic [OW-1:0]  offset_reg, offset_next;
    logic           out_valid_reg, out_valid_next;
    logic [W-1:0]   out_data_reg, out_data_next;
    logic           out_sof_reg, out_sof_next;
    logic           locked_reg, locked_next;

    logic [2*W-1:0] win;
    logic           hunt_hit;
    logic [OW-1:0]  hunt_k;
    logic [W-1:0]   cand_arr [W];
    logic [W-1:0]   cand;
    logic [FCW-1:0] fcnt_inc;
    logic           chk_beat;
    logic           sync_ok;

    assign win = {prev_reg, in_data};

    word_aligner_match #(
        .W  (W),
        .KW (OW)
    ) u_match (
        .win  (win),
        .sync (SYNC),
        .hit  (hunt_hit),
        .k    (hunt_k)
    );

    // Candidate word at the offset currently in use.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cand
            assign cand_arr[gi] = win[2*W-1-gi -: W];
        end
    endgenerate

    always_comb begin
        cand = '0;
        for (int i = 0; i < W; i++) begin
            if (offset_reg == OW'(i)) begin
                cand = cand_arr[i];
            end
        end
    end

    assign fcnt_inc = (int'(fcnt_reg) == FRAME - 1) ? '0 : fcnt_reg + FCW'(1);
    assign chk_beat = (fcnt_reg == '0);
    assign sync_ok  = (cand == SYNC);

    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        fcnt_next      = fcnt_reg;
        hits_next      = hits_reg;
        miss_next      = miss_reg;
        offset_next    = offset_reg;
        out_valid_next = 1'b0;
        out_sof_next   = 1'b0;
        out_data_next  = out_data_reg;
        locked_next    = locked_reg;

        if (in_valid) begin
            prev_next = in_data;
            case (state_reg)
                HUNT: begin
                    if (hunt_hit) begin
                        offset_next = hunt_k;
                        fcnt_next   = FCW'(1);
                        hits_next   = HCW'(1);
                        if (LOCK_N <= 1) begin
                            // Single-hit lock: this sync beat is the first output.
                            state_next     = LOCKED;
                            hits_next      = '0;
                            locked_next    = 1'b1;
                            out_valid_next = 1'b1;
                            out_sof_next   = 1'b1;
                            out_data_next  = SYNC;
                        end else begin
                            state_next = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    fcnt_next = fcnt_inc;
                    if (chk_beat) begin
                        if (sync_ok) begin
                            if (int'(hits_reg) + 1 >= LOCK_N) begin
                                // The completing hit is emitted as the first SOF.
                                state_next     = LOCKED;
                                hits_next      = '0;
                                miss_next      = '0;
                                locked_next    = 1'b1;
                                out_valid_next = 1'b1;
                                out_sof_next   = 1'b1;
                                out_data_next  = cand;
                            end else begin
                                hits_next = hits_reg + HCW'(1);
                            end
                        end else begin
                            state_next = HUNT;
                            hits_next  = '0;
                            fcnt_next  = '0;
                        end
                    end
                end

                LOCKED: begin
                    fcnt_next      = fcnt_inc;
                    out_valid_next = 1'b1;
                    out_sof_next   = chk_beat;
                    out_data_next  = cand;
                    if (chk_beat) begin
                        if (sync_ok) begin
                            miss_next = '0;
                        end else if (int'(miss_reg) + 1 >= LOSS_N) begin
                            // Lock lost: this beat is suppressed.
                            state_next     = HUNT;
                            miss_next      = '0;
                            fcnt_next      = '0;
                            locked_next    = 1'b0;
                            out_valid_next = 1'b0;
                            out_sof_next   = 1'b0;
                            out_data_next  = out_data_reg;
                        end else begin
                            miss_next = miss_reg + MCW'(1);
                        end
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            prev_reg      <= '0;
            fcnt_reg      <= '0;
            hits_reg      <= '0;
            miss_reg      <= '0;
            offset_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sof_reg   <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            fcnt_reg      <= fcnt_next;
            hits_reg      <= hits_next;
            miss_reg      <= miss_next;
            offset_reg    <= offset_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sof_reg   <= out_sof_next;
            locked_reg    <= locked_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sof   = out_sof_reg;
    assign locked    = locked_reg;
    assign offset    = offset_reg;

endmodule

// File: tb/tb_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_word_aligner
// Scoreboard bench for word_aligner with default parameters. A frame stream
// (SYNC then counter words 1..7) is shifted by k bits and packed into W-bit
// words; the expected output of each beat is queued when the beat is driven
// and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_word_aligner;

    localparam int           W    = 25;
    localparam logic [W-1:0] SYNC = 25'h1F35A4C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sof;
    logic         locked;
    logic [4:0]   offset;

    word_aligner #(
        .W      (W),
        .SYNC   (SYNC),
        .FRAME  (8),
        .LOCK_N (3),
        .LOSS_N (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .locked    (locked),
        .offset    (offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         sof;
        logic         lck;
        logic [4:0]   off;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;

    // Scenario description used to build stimulus and expectations.
    int           shift_k;
    int           n_words;
    int           first_hit;   // beat of first HUNT hit, -1 if lock must never happen
    int           loss_beat;   // beat at which lock is dropped (not emitted)
    logic [W-1:0] ovr [int];   // corrupted stream words

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Word q of the framed stream (before bit shifting).
    function automatic logic [W-1:0] frame_word(input int q);
        int fw;
        if (ovr.exists(q)) return ovr[q];
        if (q < 0 || q >= n_words) return '0;
        fw = q % 8;
        return (fw == 0) ? SYNC : W'(fw);
    endfunction

    // Word j on the wire: the framed stream delayed by shift_k zero bits.
    function automatic logic [W-1:0] chan_word(input int j);
        logic [W-1:0] r;
        logic [W-1:0] fw;
        int           p;
        int           q;
        r = '0;
        for (int i = 0; i < W; i++) begin
            p = j * W + i;
            if (p >= shift_k) begin
                q  = p - shift_k;
                fw = frame_word(q / W);
                r[W-1-i] = fw[W-1-(q % W)];
            end
        end
        return r;
    endfunction

    task automatic drive_beat(input int j);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = chan_word(j);
        e.valid  = (first_hit >= 0) && (j >= first_hit + 16) && (j < loss_beat);
        e.lck    = e.valid;
        e.data   = frame_word(j - 1);
        e.sof    = e.valid && (((j - 1) % 8) == 0);
        e.off    = 5'(shift_k);
        sb_q.push_back(e);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_sof", 32'(out_sof), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_offset", 32'(offset), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setup(input int k, input int nw, input int fh, input int lb);
        shift_k   = k;
        n_words   = nw;
        first_hit = fh;
        loss_beat = lb;
        ovr.delete();
    endtask

    // Monitor: one scoreboard entry per accepted beat, idle cycles must be quiet.
    initial begin
        logic iv;
        exp_t e;
        forever begin
            @(posedge clk);
            iv = in_valid && rst_n;
            #1;
            if (iv) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("valid", 32'(out_valid), 32'(e.valid));
                    check_val("locked", 32'(locked), 32'(e.lck));
                    check_val("sof", 32'(out_sof), 32'(e.sof));
                    if (e.valid) begin
                        check_val("data", 32'(out_data), 32'(e.data));
                        check_val("offset", 32'(offset), 32'(e.off));
                        $display("beat: data=%07h sof=%0b offset=%0d", out_data, out_sof, offset);
                    end
                end
            end else begin
                check_val("idle_valid", 32'(out_valid), 32'd0);
                check_val("idle_sof", 32'(out_sof), 32'd0);
            end
        end
    end

    initial begin
        // Offset sweep: 4 frames, lock on the 3rd sync beat (beat 17).
        for (int k = 0; k < W; k++) begin
            do_reset();
            setup(k, 32, 1, 1000);
            for (int j = 0; j <= 32; j++) drive_beat(j);
            drive_idle();
            check_val("sweep_drain", 32'(sb_q.size()), 32'd0);
        end

        // Gapped input: valid toggles 1-0-1-0.
        do_reset();
        setup(11, 32, 1, 1000);
        for (int j = 0; j <= 32; j++) begin
            drive_beat(j);
            drive_idle();
        end
        check_val("gap_drain", 32'(sb_q.size()), 32'd0);

        // False lock: one sync at offset 5, garbage where the next belongs.
        do_reset();
        setup(5, 8, -1, 1000);
        ovr[8] = 25'h0AAAAAA;
        for (int j = 0; j <= 26; j++) drive_beat(j);
        drive_idle();
        check_val("false_locked", 32'(locked), 32'd0);
        check_val("false_drain", 32'(sb_q.size()), 32'd0);

        // Loss of lock: one missed sync tolerated, two consecutive drop lock.
        do_reset();
        setup(7, 72, 1, 49);
        ovr[24] = SYNC ^ 25'h0000001;
        ovr[40] = SYNC ^ 25'h0000100;
        ovr[48] = SYNC ^ 25'h0010000;
        for (int j = 0; j <= 52; j++) drive_beat(j);
        drive_idle();
        check_val("loss_locked", 32'(locked), 32'd0);
        check_val("loss_drain", 32'(sb_q.size()), 32'd0);

        // Reset mid-frame while locked, then continue the same stream.
        do_reset();
        setup(3, 56, 1, 1000);
        for (int j = 0; j <= 19; j++) drive_beat(j);
        do_reset();
        first_hit = 25;
        for (int j = 20; j <= 50; j++) drive_beat(j);
        drive_idle();
        check_val("rstmid_drain", 32'(sb_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
